// File: rtl/axi_burst_master_pkg.sv
// rtl/axi_burst_master_pkg.sv - state encoding, AXI burst/response codes and log2 helper for axi_burst_master
package axi_burst_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - per-direction burst address generator and remaining-burst counter
module axi_burst_addr_gen
  import axi_burst_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int STRIDE = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  num,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  logic [CNT_W-1:0] remaining;

  // Address wraps naturally at 2^ADDR_W through truncating addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= num;
    end else if (advance && remaining != '0) begin
      addr      <= addr + STEP;
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - AXI burst writer with optional readback (macro AXI_BURST_READBACK_EN)
module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESET,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [CNT_W-1:0]    cfg_burst_num,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [7:0]          M_AXI_ARLEN,
  output logic [2:0]          M_AXI_ARSIZE,
  output logic [1:0]          M_AXI_ARBURST,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RLAST,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready
);

  localparam int                STRIDE    = BURST_LEN * (DATA_W / 8);
  localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);
  localparam logic [7:0]        LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [2:0]        SIZE      = 3'(log2_ceil(DATA_W / 8));

  state_t     state;
  logic [7:0] beat;
  logic       accept, misaligned, w_hs, wr_adv, wr_last, rd_adv, rd_last;

  assign accept     = (state == IDLE) && start;
  assign misaligned = (cfg_base_addr % STRIDE_A) != '0;

  assign M_AXI_AWLEN   = LAST_BEAT;
  assign M_AXI_AWSIZE  = SIZE;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_ARLEN   = LAST_BEAT;
  assign M_AXI_ARSIZE  = SIZE;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_WSTRB   = '1;

  // Write data is a zero-latency pass-through gated only by the state.
  assign M_AXI_WDATA  = s_data;
  assign M_AXI_WVALID = (state == WR_DATA) && s_valid;
  assign s_ready      = (state == WR_DATA) && M_AXI_WREADY;
  assign M_AXI_WLAST  = (state == WR_DATA) && (beat == LAST_BEAT);
  assign w_hs         = M_AXI_WVALID && M_AXI_WREADY;
  assign wr_adv       = (state == WR_RESP) && M_AXI_BVALID;

`ifdef AXI_BURST_READBACK_EN
  logic r_hs;
  assign rd_data      = M_AXI_RDATA;
  assign rd_valid     = (state == RD_DATA) && M_AXI_RVALID;
  assign M_AXI_RREADY = (state == RD_DATA) && rd_ready;
  assign r_hs         = M_AXI_RVALID && M_AXI_RREADY;
  assign rd_adv       = r_hs && (beat == LAST_BEAT);
`else
  logic unused_rd;
  assign rd_data      = '0;
  assign rd_valid     = 1'b0;
  assign M_AXI_RREADY = 1'b0;
  assign rd_adv       = 1'b0;
  assign unused_rd    = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
                          M_AXI_RVALID, rd_ready, rd_last};
`endif

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .STRIDE(STRIDE)) u_wr_gen (
    .clk(M_AXI_ACLK), .rst(M_AXI_ARESET), .load(accept), .advance(wr_adv),
    .base(cfg_base_addr), .num(cfg_burst_num), .addr(M_AXI_AWADDR), .last(wr_last)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .STRIDE(STRIDE)) u_rd_gen (
    .clk(M_AXI_ACLK), .rst(M_AXI_ARESET), .load(accept), .advance(rd_adv),
    .base(cfg_base_addr), .num(cfg_burst_num), .addr(M_AXI_ARADDR), .last(rd_last)
  );

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      beat          <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy  <= 1'b1;
          error <= 1'b0;
          if (misaligned) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= FINISH;
          end else if (cfg_burst_num == '0) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            M_AXI_AWVALID <= 1'b1;
            state         <= WR_ADDR;
          end
        end
        WR_ADDR: if (M_AXI_AWREADY) begin
          M_AXI_AWVALID <= 1'b0;
          state         <= WR_DATA;
        end
        WR_DATA: if (w_hs) begin
          if (beat == LAST_BEAT) begin
            beat         <= '0;
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end else begin
            beat <= beat + 8'd1;
          end
        end
        WR_RESP: if (M_AXI_BVALID) begin
          M_AXI_BREADY <= 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) error <= 1'b1;
          if (!wr_last) begin
            M_AXI_AWVALID <= 1'b1;
            state         <= WR_ADDR;
          end else begin
`ifdef AXI_BURST_READBACK_EN
            M_AXI_ARVALID <= 1'b1;
            state         <= RD_ADDR;
`else
            done  <= 1'b1;
            state <= FINISH;
`endif
          end
        end
`ifdef AXI_BURST_READBACK_EN
        RD_ADDR: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          state         <= RD_DATA;
        end
        RD_DATA: if (r_hs) begin
          if (M_AXI_RRESP != RESP_OKAY) error <= 1'b1;
          if ((beat == LAST_BEAT) != M_AXI_RLAST) error <= 1'b1;
          if (beat == LAST_BEAT) begin
            beat <= '0;
            if (!rd_last) begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end else begin
            beat <= beat + 8'd1;
          end
        end
`endif
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - table-driven and randomized bench for axi_burst_master with a memory-backed slave model
module tb_axi_burst_master;

  localparam int DW     = 128;
  localparam int AW     = 32;
  localparam int BL     = 4;
  localparam int CW     = 16;
  localparam int BYTES  = DW / 8;
  localparam int STRIDE = BL * BYTES;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [AW-1:0] cfg_base_addr;
  logic [CW-1:0] cfg_burst_num;
  logic [DW-1:0] s_data;
  logic s_valid, s_ready, busy, done, error;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready, rd_valid, rd_ready;
  logic [DW-1:0] wdata, rdata, rd_data;
  logic [DW/8-1:0] wstrb;

  always #5 clk = ~clk;

  axi_burst_master #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_burst_num(cfg_burst_num),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done(done), .error(error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
  );

  int total = 0;
  int bad   = 0;

  int seed_w, stall, bad_burst, early_rlast;
  int src_idx, wcount, bcount, pend_b, done_count, rcount, rbeat;
  bit src_en, b_hs, r_hs, aw_hold;
  logic [AW-1:0] prev_awaddr;
  logic [AW-1:0] aw_list[$];
  logic [AW-1:0] ar_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int seed, input int n);
    return {32'(seed), 32'(n), ~32'(seed), 32'(n * 3 + 1)};
  endfunction

  function automatic bit rnd();
    return (stall != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
  endfunction

  // Slave, source and monitor: drive on the falling edge, sample 1ns later.
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; s_valid = 0; s_data = 0; rd_ready = 0;
    forever begin
      @(negedge clk);
      awready  = rnd();
      wready   = rnd();
      arready  = rnd();
      rd_ready = rnd();
      s_valid  = src_en && rnd();
      s_data   = pattern(seed_w, src_idx);
      if (b_hs) bvalid = 1'b0;
      if (!bvalid && pend_b > 0 && rnd()) begin
        bvalid = 1'b1;
        bresp  = (bcount == bad_burst) ? 2'b10 : 2'b00;
      end
      if (r_hs) rvalid = 1'b0;
      if (!rvalid && ar_q.size() > 0 && rnd()) begin
        logic [AW-1:0] ra;
        ra     = ar_q[0] + AW'(rbeat * BYTES);
        rvalid = 1'b1;
        rdata  = mem.exists(ra) ? mem[ra] : '0;
        rresp  = 2'b00;
        rlast  = (rbeat == BL - 1) || (early_rlast != 0 && rbeat == 1);
      end
      #1;
      b_hs = bvalid && bready;
      r_hs = rvalid && rready;
      if (awvalid && aw_hold) check("awaddr_stable", awaddr, prev_awaddr);
      aw_hold     = awvalid && !awready;
      prev_awaddr = awaddr;
      if (awvalid && awready) aw_list.push_back(awaddr);
      if (s_valid && s_ready) src_idx++;
      if (wvalid && wready) begin
        check("wdata", wdata, pattern(seed_w, wcount));
        check("wlast", DW'(wlast), DW'((wcount % BL) == BL - 1));
        if (aw_list.size() > wcount / BL)
          mem[aw_list[wcount / BL] + AW'((wcount % BL) * BYTES)] = wdata;
        if ((wcount % BL) == BL - 1) pend_b++;
        wcount++;
      end
      if (b_hs) begin
        pend_b--;
        bcount++;
      end
      if (arvalid && arready) ar_q.push_back(araddr);
      if (r_hs) begin
        rbeat++;
        if (rbeat == BL) begin
          rbeat = 0;
          void'(ar_q.pop_front());
        end
      end
      if (rd_valid && rd_ready) begin
        check("rd_data", rd_data, pattern(seed_w, rcount));
        rcount++;
      end
      if (done) done_count++;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_model(input int seed);
    seed_w = seed; src_idx = 0; wcount = 0; bcount = 0; pend_b = 0;
    done_count = 0; rcount = 0; rbeat = 0;
    aw_list.delete(); ar_q.delete(); mem.delete();
    b_hs = 0; r_hs = 0; aw_hold = 0; bvalid = 0; rvalid = 0;
  endtask

  task automatic run_job(input logic [AW-1:0] base, input int num, input int badb,
                         input int stl, input int early, input int exp_bursts, input bit exp_err);
    int cycles;
    clear_model(int'($urandom));
    stall = stl; bad_burst = badb; early_rlast = early;
    cfg_base_addr = base;
    cfg_burst_num = CW'(num);
    start = 1'b1;
    src_en = 1'b1;
    step();
    start = 1'b0;
    check("error_at_start", DW'(error), DW'((base % STRIDE) != 0));
    cycles = 0;
    while (done_count == 0 && cycles < 3000) begin
      step();
      cycles++;
    end
    check("done_seen", DW'(done_count != 0), DW'(1));
    check("error_at_done", DW'(error), DW'(exp_err));
    src_en = 1'b0;
    step();
    step();
    check("busy_after", DW'(busy), DW'(0));
    check("done_once", DW'(done_count), DW'(1));
    check("error_sticky", DW'(error), DW'(exp_err));
    check("aw_count", DW'(aw_list.size()), DW'(exp_bursts));
    for (int k = 0; k < exp_bursts && k < aw_list.size(); k++)
      check("awaddr", DW'(aw_list[k]), DW'(AW'(base + AW'(k * STRIDE))));
    check("w_beats", DW'(wcount), DW'(exp_bursts * BL));
`ifdef AXI_BURST_READBACK_EN
    check("r_beats", DW'(rcount), DW'(exp_bursts * BL));
`endif
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int num;
    int badb;
    int stl;
    int exp_bursts;
    bit exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cycles;
    vecs[0] = '{32'h4000_0000, 3, -1, 0, 3, 1'b0};
    vecs[1] = '{32'h4000_0000, 5, -1, 1, 5, 1'b0};
    vecs[2] = '{32'hFFFF_FF80, 3, -1, 1, 3, 1'b0};
    vecs[3] = '{32'h4000_0010, 2, -1, 0, 0, 1'b1};
    vecs[4] = '{32'h4000_0000, 0, -1, 0, 0, 1'b0};
    vecs[5] = '{32'h4000_0000, 3,  1, 0, 3, 1'b1};
    vecs[6] = '{32'h4000_0000, 2, -1, 1, 2, 1'b0};
    vecs[7] = '{32'h0000_0040, 1,  0, 1, 1, 1'b1};

    rst = 1'b1; start = 1'b0; src_en = 1'b0; stall = 0; bad_burst = -1; early_rlast = 0;
    cfg_base_addr = '0; cfg_burst_num = '0;
    clear_model(1);
    step();
    step();
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_error", DW'(error), DW'(0));
    check("rst_awvalid", DW'(awvalid), DW'(0));
    check("rst_wvalid", DW'(wvalid), DW'(0));
    check("rst_s_ready", DW'(s_ready), DW'(0));
    check("rst_awaddr", DW'(awaddr), DW'(0));
    check("rst_arvalid", DW'(arvalid), DW'(0));
    check("rst_rd_valid", DW'(rd_valid), DW'(0));
    check("awlen", DW'(awlen), DW'(BL - 1));
    check("awsize", DW'(awsize), DW'(4));
    check("awburst", DW'(awburst), DW'(1));
    check("wstrb", DW'(wstrb), DW'(16'hFFFF));
    rst = 1'b0;
    step();

    foreach (vecs[i])
      run_job(vecs[i].base, vecs[i].num, vecs[i].badb, vecs[i].stl, 0,
              vecs[i].exp_bursts, vecs[i].exp_err);

    // Zero-burst job: done follows the accepting edge directly, no address phase.
    clear_model(5);
    stall = 0; bad_burst = -1;
    cfg_base_addr = 32'h4000_0000; cfg_burst_num = '0; start = 1'b1;
    step();
    start = 1'b0;
    check("zero_done", DW'(done), DW'(1));
    check("zero_busy", DW'(busy), DW'(1));
    check("zero_awvalid", DW'(awvalid), DW'(0));
    step();
    check("zero_done_end", DW'(done), DW'(0));
    check("zero_busy_end", DW'(busy), DW'(0));
    check("zero_no_aw", DW'(aw_list.size()), DW'(0));

    // Reset in the middle of a write burst, then a clean job.
    clear_model(77);
    stall = 0; bad_burst = -1;
    cfg_base_addr = 32'h4000_0000; cfg_burst_num = CW'(3); start = 1'b1; src_en = 1'b1;
    step();
    start = 1'b0;
    cycles = 0;
    while (wcount < 2 && cycles < 200) begin
      step();
      cycles++;
    end
    check("reach_wdata", DW'(wcount >= 2), DW'(1));
    rst = 1'b1;
    step();
    check("midrst_wvalid", DW'(wvalid), DW'(0));
    check("midrst_busy", DW'(busy), DW'(0));
    check("midrst_awvalid", DW'(awvalid), DW'(0));
    check("midrst_bready", DW'(bready), DW'(0));
    rst = 1'b0;
    src_en = 1'b0;
    step();
    run_job(32'h4000_0000, 3, -1, 1, 0, 3, 1'b0);

    for (int j = 0; j < 6; j++) begin
      logic [AW-1:0] b;
      int n, bb;
      bit mis;
      mis = ($urandom_range(0, 4) == 0);
      b   = ($urandom & ~32'(STRIDE - 1)) | (mis ? 32'h10 : 32'h0);
      n   = mis ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 5));
      bb  = int'($urandom_range(0, 7));
      run_job(b, n, bb, 1, 0, mis ? 0 : n, mis || (bb < n));
    end

`ifdef AXI_BURST_READBACK_EN
    run_job(32'h4000_0000, 2, -1, 1, 1, 2, 1'b1);
    run_job(32'h2000_0000, 3, -1, 1, 0, 3, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 SHALL have parameter DATA_W, default 128, AXI data width in bits (32/64/128/256).
REQ-002 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-003 SHALL have parameter BURST_LEN, default 256, beats per burst (1..256).
REQ-004 SHALL have parameter CNT_W, default 16, width of the runtime burst-count input.
REQ-005 SHALL have port M_AXI_ACLK, in, 1, single clock; all logic rising-edge.
REQ-006 SHALL have port M_AXI_ARESET, in, 1, synchronous active-high reset.
REQ-007 SHALL have port start, in, 1, job request pulse.
REQ-008 SHALL have port cfg_base_addr, in, ADDR_W, job start address, sampled on accepted start.
REQ-009 SHALL have port cfg_burst_num, in, CNT_W, bursts per job, sampled on accepted start.
REQ-010 SHALL have ports s_data, in, DATA_W; s_valid, in, 1; s_ready, out, 1: capture data stream.
REQ-011 SHALL have ports busy, out, 1; done, out, 1 (one-cycle pulse); error, out, 1 (sticky).
REQ-012 SHALL have AW ports M_AXI_AWADDR/AWLEN[8]/AWSIZE[3]/AWBURST[2]/AWVALID out and AWREADY in.
REQ-013 SHALL have W ports M_AXI_WDATA/WSTRB/WLAST/WVALID out and WREADY in; B ports BRESP[2]/BVALID in and BREADY out.
REQ-014 SHALL have AR ports ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID out and ARREADY in; R ports RDATA/RRESP/RLAST/RVALID in and RREADY out; plus rd_data, out, DATA_W; rd_valid, out, 1; rd_ready, in, 1.

Function
REQ-015 SHALL implement states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, FINISH.
REQ-016 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-017 On accepted start with cfg_burst_num=0, SHALL go to FINISH and pulse done the next cycle, issuing no transactions.
REQ-018 On accepted start with cfg_base_addr not aligned to BURST_LEN*DATA_W/8, SHALL set error, pulse done, and issue no transactions.
REQ-019 Burst k address SHALL be base + k*BURST_LEN*DATA_W/8, computed modulo 2^ADDR_W. AWLEN/ARLEN SHALL be BURST_LEN-1, SIZE log2(DATA_W/8), BURST INCR, WSTRB all ones.
REQ-020 AWVALID/ARVALID SHALL assert on WR_ADDR/RD_ADDR entry and hold, with stable address, until READY.
REQ-021 In WR_DATA: WVALID=s_valid, s_ready=WREADY, WDATA=s_data, combinational pass-through with zero latency. s_ready SHALL be 0 in every other state.
REQ-022 WLAST SHALL be asserted exactly on beat BURST_LEN-1 (beat 0 when BURST_LEN=1).
REQ-023 In WR_RESP, BREADY SHALL be 1. A nonzero BRESP SHALL set error. SHALL then go to WR_ADDR if bursts remain, otherwise to the read phase or FINISH.
REQ-024 busy SHALL be 1 in every state except IDLE. done SHALL pulse in FINISH, then return to IDLE.
REQ-025 error SHALL clear only on the next accepted start or on reset.

Reset
REQ-026 M_AXI_ARESET SHALL force IDLE and all VALID/READY/LAST outputs, busy, done, error, and counters to 0 on the next edge, including mid-burst.
REQ-027 Address outputs SHALL reset to 0. No partial-burst completion is required after reset.

Configuration
REQ-028 With macro AXI_BURST_READBACK_EN defined, after the final B response SHALL read the same region using the same burst addressing. In RD_DATA: rd_data=RDATA, rd_valid=RVALID, RREADY=rd_ready.
REQ-029 With the macro, nonzero RRESP SHALL set error. RLAST absent on beat BURST_LEN-1, or present earlier, SHALL set error.
REQ-030 Without the macro, RD states SHALL be unreachable, ARVALID/RREADY/rd_valid SHALL be tied 0, and ports SHALL remain present.

Structure
REQ-031 A shared package SHALL hold the state enum, the AXI BURST/RESP encodings, and a log2 helper constant function.
REQ-032 One sub-module, axi_burst_addr_gen, SHALL generate burst addresses and count bursts; it SHALL be instantiated once per direction.

Verification
REQ-033 Test: BURST_LEN=4, base 0x40000000, num=3, slave always ready. Require AWADDR 0x40000000/0x40000040/0x40000080, 12 W beats, WLAST on beats 3/7/11, one done pulse.
REQ-034 Test: random WREADY/s_valid/AWREADY stalls. Require W beats to equal s_data order exactly and AWADDR to stay stable while AWVALID=1.
REQ-035 Test: num=0. Require done the cycle after FINISH, no AWVALID. Test: base 0x40000010. Require error=1 and no AWVALID.
REQ-036 Test: BRESP=2'b10 on burst 2 of 3. Require error sticky through done. Require error clear on the next start.
REQ-037 Test: assert M_AXI_ARESET mid-WR_DATA. Require WVALID=0, busy=0 next cycle; then a new start completes normally.
REQ-038 Test with AXI_BURST_READBACK_EN: after writes, require rd_data to equal written data under rd_ready throttling. Early RLAST SHALL set error.
